// File: rtl/des_key_schedule_if.sv
// Request/response bundle between the DES round stage and its key schedule.
interface des_key_schedule_if;
    logic        init;
    logic        decrypt;
    logic [63:0] key;
    logic        next;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        fKey;
    logic        done;

    modport master (
        output init, decrypt, key, next,
        input  subkey, round, fKey, done
    );

    modport slave (
        input  init, decrypt, key, next,
        output subkey, round, fKey, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// DES subkey generator: one 48-bit subkey per round, encrypt or decrypt order.
module des_key_schedule (
    input  logic              clk,
    input  logic              reset,
    des_key_schedule_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    // Standard bit 1 sits at the MSB, so a DES left rotate is a vector left rotate.
    function automatic logic [27:0] rol(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic shift_two(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    state_t      state, state_nxt;
    logic [27:0] c, d, c_nxt, d_nxt;
    logic [3:0]  rnd, rnd_nxt;
    logic        dir, dir_nxt;
    logic        done_q, done_nxt;
    logic [55:0] cd_key;
    logic        enc_two, dec_two;

    assign cd_key  = pc1(bus.key);
    assign enc_two = shift_two({1'b0, rnd} + 5'd2);
    assign dec_two = shift_two(5'd16 - {1'b0, rnd});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            c      <= '0;
            d      <= '0;
            rnd    <= '0;
            dir    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            c      <= c_nxt;
            d      <= d_nxt;
            rnd    <= rnd_nxt;
            dir    <= dir_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        c_nxt     = c;
        d_nxt     = d;
        rnd_nxt   = rnd;
        dir_nxt   = dir;
        done_nxt  = 1'b0;
        if (bus.init) begin
            // Decrypt starts from the fully rotated halves, which equal PC-1 itself.
            c_nxt     = bus.decrypt ? cd_key[55:28] : rol(cd_key[55:28], 1'b0);
            d_nxt     = bus.decrypt ? cd_key[27:0]  : rol(cd_key[27:0], 1'b0);
            rnd_nxt   = '0;
            dir_nxt   = bus.decrypt;
            state_nxt = RUN;
        end else if (state == RUN && bus.next) begin
            if (rnd == 4'd15) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                rnd_nxt   = '0;
            end else begin
                c_nxt   = dir ? ror(c, dec_two) : rol(c, enc_two);
                d_nxt   = dir ? ror(d, dec_two) : rol(d, enc_two);
                rnd_nxt = rnd + 4'd1;
            end
        end
    end

    always_comb begin
        bus.fKey   = (state == RUN);
        bus.done   = done_q;
        bus.round  = rnd;
        bus.subkey = pc2({c, d});
    end
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed checks of the DES key schedule against the published 133457799BBCDFF1 subkeys.
module tb_des_key_schedule;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    des_key_schedule_if bus ();

    des_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEYP = 64'h123556789ABCDEF0;

    logic [47:0] ks [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] k, input logic dec, input logic nx);
        bus.init    = 1'b1;
        bus.key     = k;
        bus.decrypt = dec;
        bus.next    = nx;
        tick();
        bus.init    = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.init    = 1'b0;
        bus.decrypt = 1'b0;
        bus.key     = '0;
        bus.next    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_fkey", 64'(bus.fKey), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_round", 64'(bus.round), 64'd0);
        chk("rst_subkey", 64'(bus.subkey), 64'd0);

        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        chk("idle_next_fkey", 64'(bus.fKey), 64'd0);
        chk("idle_next_round", 64'(bus.round), 64'd0);

        start(KEY, 1'b0, 1'b0);
        chk("enc_fkey", 64'(bus.fKey), 64'd1);
        chk("enc_r0", 64'(bus.round), 64'd0);
        chk("enc_k1", 64'(bus.subkey), 64'(ks[0]));
        tick();
        tick();
        chk("enc_hold_k1", 64'(bus.subkey), 64'(ks[0]));
        chk("enc_hold_r0", 64'(bus.round), 64'd0);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        chk("enc_r1", 64'(bus.round), 64'd1);
        chk("enc_k2", 64'(bus.subkey), 64'(ks[1]));
        tick();
        chk("enc_hold_k2", 64'(bus.subkey), 64'(ks[1]));
        bus.next = 1'b1;
        for (int r = 2; r < 16; r++) begin
            tick();
            chk($sformatf("enc_round%0d", r), 64'(bus.round), 64'(r));
            chk($sformatf("enc_k%0d", r + 1), 64'(bus.subkey), 64'(ks[r]));
        end
        tick();
        bus.next = 1'b0;
        chk("enc_end_fkey", 64'(bus.fKey), 64'd0);
        chk("enc_end_done", 64'(bus.done), 64'd1);
        chk("enc_end_round", 64'(bus.round), 64'd0);
        tick();
        chk("enc_done_drop", 64'(bus.done), 64'd0);

        start(KEY, 1'b1, 1'b1);
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("dec_round%0d", r), 64'(bus.round), 64'(r));
            chk($sformatf("dec_k%0d", 16 - r), 64'(bus.subkey), 64'(ks[15-r]));
            chk($sformatf("dec_fkey%0d", r), 64'(bus.fKey), 64'd1);
            tick();
        end
        chk("dec_end_done", 64'(bus.done), 64'd1);
        chk("dec_end_fkey", 64'(bus.fKey), 64'd0);
        bus.next = 1'b0;
        tick();
        chk("dec_done_drop", 64'(bus.done), 64'd0);

        start(KEY, 1'b0, 1'b1);
        for (int r = 0; r < 9; r++) tick();
        chk("reinit_pre_round", 64'(bus.round), 64'd9);
        chk("reinit_pre_k10", 64'(bus.subkey), 64'(ks[9]));
        start(64'd0, 1'b0, 1'b1);
        bus.next = 1'b0;
        chk("reinit_round", 64'(bus.round), 64'd0);
        chk("reinit_subkey", 64'(bus.subkey), 64'd0);
        chk("reinit_fkey", 64'(bus.fKey), 64'd1);
        chk("reinit_done", 64'(bus.done), 64'd0);

        start(KEYP, 1'b0, 1'b1);
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("parity_k%0d", r + 1), 64'(bus.subkey), 64'(ks[r]));
            tick();
        end
        bus.next = 1'b0;
        chk("parity_done", 64'(bus.done), 64'd1);

        start(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);
        chk("ones_k16", 64'(bus.subkey), 64'hFFFFFFFFFFFF);

        start(KEY, 1'b0, 1'b1);
        for (int r = 0; r < 7; r++) tick();
        bus.next = 1'b0;
        chk("mid_round7", 64'(bus.round), 64'd7);
        chk("mid_k8", 64'(bus.subkey), 64'(ks[7]));
        reset = 1'b1;
        #2;
        chk("async_fkey", 64'(bus.fKey), 64'd0);
        chk("async_done", 64'(bus.done), 64'd0);
        chk("async_round", 64'(bus.round), 64'd0);
        chk("async_subkey", 64'(bus.subkey), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_fkey", 64'(bus.fKey), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
